// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings and default vectors for the fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, PEND = 2'd2} state_e;
    // Numeric order matches redirect priority so sources compare directly.
    typedef enum logic [2:0] {SRC_NONE, SRC_BR, SRC_JMP, SRC_ERET, SRC_EXC} src_e;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: PC, hazard, redirect and IF/ID control bundle of the fetch sequencer.
interface fetch_sequencer_if #(parameter int CNT_W = 32);
    logic [31:0] pc;
    logic imem_ready;
    logic load_use;
    logic br_taken;
    logic [31:0] br_target;
    logic jmp;
    logic [31:0] jmp_target;
    logic exc_req;
    logic eret;
    logic [31:0] epc;
    logic [31:0] npc;
    logic pc_we;
    logic imem_req;
    logic ifid_we;
    logic ifid_flush;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        input pc, imem_ready, load_use, br_taken, br_target, jmp, jmp_target, exc_req, eret, epc,
        output npc, pc_we, imem_req, ifid_we, ifid_flush, stall_cycles
    );
    modport slave (
        output pc, imem_ready, load_use, br_taken, br_target, jmp, jmp_target, exc_req, eret, epc,
        input npc, pc_we, imem_req, ifid_we, ifid_flush, stall_cycles
    );
endinterface

// File: rtl/redirect_select.sv
// redirect_select: priority mux over exception, ERET, jump and branch redirects.
module redirect_select
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        br_i,
    input  logic [31:0] br_target_i,
    input  logic        load_use_i,
    output logic        valid_o,
    output src_e        src_o,
    output logic [31:0] target_o
);
    always_comb begin
        src_o = exc_i ? SRC_EXC : eret_i ? SRC_ERET : (jmp_i && !load_use_i) ? SRC_JMP :
                (br_i && !load_use_i) ? SRC_BR : SRC_NONE;
        target_o = word_align(exc_i ? EXC_VECTOR : eret_i ? epc_i :
                              (jmp_i && !load_use_i) ? jmp_target_i : br_target_i);
        valid_o = src_o != SRC_NONE;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC selection, IF/ID control and fetch-wait redirect tracking.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic clrn,
    fetch_sequencer_if.master bus
);
    state_e state_q, state_d;
    src_e src_q, src_d;
    logic [31:0] redir_q, redir_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] npc;
    logic pc_we, imem_req, ifid_we, ifid_flush;
    logic rv;
    src_e rsrc;
    logic [31:0] rtgt;

    redirect_select #(.EXC_VECTOR(EXC_VECTOR)) u_sel (
        .exc_i(bus.exc_req), .eret_i(bus.eret), .epc_i(bus.epc),
        .jmp_i(bus.jmp), .jmp_target_i(bus.jmp_target),
        .br_i(bus.br_taken), .br_target_i(bus.br_target),
        .load_use_i(bus.load_use),
        .valid_o(rv), .src_o(rsrc), .target_o(rtgt)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= BOOT;
            src_q <= SRC_NONE;
            redir_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            src_q <= src_d;
            redir_q <= redir_d;
            cnt_q <= (!pc_we && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d = src_q;
        redir_d = redir_q;
        npc = bus.pc + 32'd4;
        pc_we = 1'b0;
        imem_req = 1'b1;
        ifid_we = 1'b0;
        ifid_flush = 1'b0;
        if (!clrn) begin
            npc = RESET_VECTOR;
            pc_we = 1'b1;
            imem_req = 1'b0;
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    imem_req = 1'b0;
                    ifid_flush = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.imem_ready) begin
                        npc = rv ? rtgt : npc;
                        pc_we = rv || !bus.load_use;
                        ifid_we = rv || !bus.load_use;
                        ifid_flush = rv;
                    end else begin
                        ifid_flush = 1'b1;
                        ifid_we = !rv;
                        if (rv) begin
                            redir_d = rtgt;
                            src_d = rsrc;
                            state_d = PEND;
                        end
                    end
                end
                PEND: begin
                    ifid_flush = 1'b1;
                    ifid_we = 1'b1;
                    // The in-flight word is discarded; a same-cycle redirect beats the saved one.
                    if (bus.imem_ready) begin
                        pc_we = 1'b1;
                        npc = rv ? rtgt : redir_q;
                        src_d = SRC_NONE;
                        state_d = RUN;
                    end else if (rv && rsrc >= src_q) begin
                        redir_d = rtgt;
                        src_d = rsrc;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    assign bus.npc = npc;
    assign bus.pc_we = pc_we;
    assign bus.imem_req = imem_req;
    assign bus.ifid_we = ifid_we;
    assign bus.ifid_flush = ifid_flush;
    assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a behavioural front-end model and random stimulus.
module tb_fetch_sequencer;
    localparam logic [31:0] EXC = 32'h8000_0180;
    localparam logic [31:0] RV = 32'h0000_0000;

    typedef struct {
        logic [31:0] npc; bit npc_k;
        logic pc_we; logic req;
        logic we; bit we_k;
        logic flush; bit flush_k;
        longint cnt; bit cnt_k;
        logic [31:0] pc; bit pc_k;
    } exp_t;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic [31:0] pc_q;
    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    bit m_boot = 1'b0, m_pend = 1'b0, m_cnt_k = 1'b0, m_pc_k = 1'b0;
    logic [31:0] m_pc = '0, m_ptgt = '0;
    int m_prank = 0;
    longint m_cnt = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.CNT_W(32)) bus();
    fetch_sequencer_if #(.CNT_W(4)) bus4();

    fetch_sequencer dut (.clk(clk), .clrn(clrn), .bus(bus.master));
    fetch_sequencer #(.CNT_W(4)) dut4 (.clk(clk), .clrn(clrn), .bus(bus4.master));

    always @(posedge clk) if (bus.pc_we) pc_q <= bus.npc;

    assign bus.pc = pc_q;
    assign bus4.pc = pc_q;
    assign bus4.imem_ready = bus.imem_ready;
    assign bus4.load_use = bus.load_use;
    assign bus4.br_taken = bus.br_taken;
    assign bus4.br_target = bus.br_target;
    assign bus4.jmp = bus.jmp;
    assign bus4.jmp_target = bus.jmp_target;
    assign bus4.exc_req = bus.exc_req;
    assign bus4.eret = bus.eret;
    assign bus4.epc = bus.epc;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_we", 32'(bus.pc_we), 32'(e.pc_we));
            chk("imem_req", 32'(bus.imem_req), 32'(e.req));
            if (e.we_k) chk("ifid_we", 32'(bus.ifid_we), 32'(e.we));
            if (e.flush_k) chk("ifid_flush", 32'(bus.ifid_flush), 32'(e.flush));
            if (e.npc_k) chk("npc", bus.npc, e.npc);
            if (e.pc_k) chk("pc", bus.pc, e.pc);
            if (e.cnt_k) begin
                chk("stall_cycles", bus.stall_cycles, 32'(e.cnt > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : e.cnt));
                chk("stall_cycles_w4", 32'(bus4.stall_cycles), 32'(e.cnt > 15 ? 15 : e.cnt));
            end
        end
    end

    task automatic cyc(input bit rn, input bit rdy, input bit lu, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit ex, input bit er, input logic [31:0] ep);
        exp_t e;
        int rank;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        clrn = rn;
        bus.imem_ready = rdy; bus.load_use = lu;
        bus.br_taken = br; bus.br_target = bt;
        bus.jmp = j; bus.jmp_target = jt;
        bus.exc_req = ex; bus.eret = er; bus.epc = ep;
        rank = ex ? 4 : er ? 3 : (j && !lu) ? 2 : (br && !lu) ? 1 : 0;
        tgt = ex ? EXC : er ? ep : (j && !lu) ? jt : bt;
        tgt[1:0] = 2'b00;
        e.npc = '0; e.npc_k = 1'b0; e.pc_we = 1'b0; e.req = 1'b1;
        e.we = 1'b0; e.we_k = 1'b1; e.flush = 1'b0; e.flush_k = 1'b1;
        e.cnt = m_cnt; e.cnt_k = m_cnt_k; e.pc = m_pc; e.pc_k = m_pc_k;
        if (!rn) begin
            e.npc = RV; e.npc_k = 1'b1; e.pc_we = 1'b1; e.req = 1'b0; e.flush = 1'b1;
            m_boot = 1'b1; m_pend = 1'b0;
        end else if (m_boot) begin
            e.req = 1'b0; e.we_k = 1'b0; e.flush = 1'b1;
            m_boot = 1'b0;
        end else if (!m_pend) begin
            if (rdy) begin
                if (rank != 0) begin
                    e.npc = tgt; e.npc_k = 1'b1; e.pc_we = 1'b1; e.we = 1'b1; e.flush = 1'b1;
                end else if (!lu) begin
                    e.npc = m_pc + 32'd4; e.npc_k = 1'b1; e.pc_we = 1'b1; e.we = 1'b1;
                end
            end else begin
                e.we = (rank == 0); e.flush = 1'b1; e.flush_k = (rank == 0);
                if (rank != 0) begin
                    m_pend = 1'b1; m_ptgt = tgt; m_prank = rank;
                end
            end
        end else begin
            e.we = 1'b1; e.flush = 1'b1;
            if (rdy) begin
                e.pc_we = 1'b1; e.npc = (rank != 0) ? tgt : m_ptgt; e.npc_k = 1'b1;
                m_pend = 1'b0;
            end else if (rank != 0 && rank >= m_prank) begin
                m_ptgt = tgt; m_prank = rank;
            end
        end
        if (e.pc_we) begin
            m_pc = e.npc; m_pc_k = 1'b1;
        end
        if (!rn) begin
            m_cnt = 0; m_cnt_k = 1'b1;
        end else if (!e.pc_we && m_cnt < 64'hFFFF_FFFF) begin
            m_cnt++;
        end
        q.push_back(e);
    endtask

    task automatic run(input bit rdy);
        cyc(1, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.imem_ready = 1'b0; bus.load_use = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
        bus.jmp = 1'b0; bus.jmp_target = '0; bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = '0;
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) run(1);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        run(1);
        cyc(1, 1, 1, 1, 32'h40, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 32'h40, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 32'h20, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        run(0);
        run(0);
        run(1);
        cyc(1, 1, 0, 1, 32'h44, 0, 0, 1, 1, 32'h200);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h200);
        cyc(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        run(1);
        repeat (20) run(0);
        run(1);
        cyc(1, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) run(1);
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 6) == 0,
                $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 6) == 0, $urandom,
                $urandom_range(0, 12) == 0, $urandom_range(0, 9) == 0, $urandom);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected responses left, required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
